tow_cpu_presser: RTL and testbench

- Computer-opponent press transmitter for the tug-of-war game.
- Generates an active-low, KEY-style button waveform (press held, then released) at a rate set by a difficulty setting.
- Its output drives a tow_input instance, which is the receiver: it turns the waveform into one-cycle actions.
- Replaces the ad-hoc LFSR + comparator path. The waveform guarantees a clean press/release edge that tow_input can always detect.

---
 rtl/tow_pkg.sv | 12 +
 rtl/tow_cpu_presser_lfsr_xnor.sv | 15 +
 rtl/tow_cpu_presser.sv | 112 +++++++++++
 tb/tb_tow_cpu_presser.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war CPU opponent.
package tow_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} presser_state_t;

  localparam logic [3:0] PRESS_CNT_MAX = 4'd15;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == PRESS_CNT_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/tow_cpu_presser_lfsr_xnor.sv
// Free-running XNOR-feedback LFSR; resets to zero, all-ones lock-up state unreachable.
module lfsr_xnor #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= {q[WIDTH-2:0], ~(q[WIDTH-1] ^ q[WIDTH-4])};
  end

endmodule

// File: rtl/tow_cpu_presser.sv
// Computer-opponent button emulator: emits active-low press/release waveforms
// whose rate follows a difficulty threshold compared against an LFSR.
module tow_cpu_presser
  import tow_pkg::*;
#(
  parameter int unsigned WIDTH       = 10,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-2:0] difficulty,
  output logic             key_n,
  output logic             busy,
  output logic [3:0]       press_count,
  output logic [WIDTH-1:0] lfsr_q
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  presser_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           key_n_q, key_n_d;
  logic           busy_q, busy_d;
  logic [3:0]     press_count_q, press_count_d;
  logic           trig;

  lfsr_xnor #(.WIDTH(WIDTH)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  // All-ones difficulty is forced to fire so "max" mode is fully deterministic.
  assign trig = enable & ((&difficulty) | ({1'b0, difficulty} > lfsr_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      key_n_q       <= 1'b1;
      busy_q        <= 1'b0;
      press_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      key_n_q       <= key_n_d;
      busy_q        <= busy_d;
      press_count_q <= press_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (!enable || cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    key_n_d       = 1'b1;
    busy_d        = busy_q;
    press_count_d = press_count_q;
    case (state_q)
      IDLE: begin
        if (trig) begin
          key_n_d       = 1'b0;
          busy_d        = 1'b1;
          press_count_d = sat_inc4(press_count_q);
        end
      end
      HOLD: begin
        if (enable && cnt_q != '0) key_n_d = 1'b0;
      end
      GAP: begin
        if (cnt_q == '0) busy_d = 1'b0;
      end
      default: busy_d = 1'b0;
    endcase
  end

  assign key_n       = key_n_q;
  assign busy        = busy_q;
  assign press_count = press_count_q;

endmodule

// File: tb/tb_tow_cpu_presser.sv
// Scoreboard bench for tow_cpu_presser: directed scenarios plus randomized traffic.
module tb_tow_cpu_presser;

  localparam int unsigned W = 10;
  localparam int unsigned H = 2;
  localparam int unsigned G = 2;
  localparam int DMAX = (1 << (W - 1)) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-2:0] difficulty;
  logic         key_n;
  logic         busy;
  logic [3:0]   press_count;
  logic [W-1:0] lfsr_q;

  always #5 clk = ~clk;

  tow_cpu_presser #(
    .WIDTH       (W),
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .difficulty  (difficulty),
    .key_n       (key_n),
    .busy        (busy),
    .press_count (press_count),
    .lfsr_q      (lfsr_q)
  );

  typedef struct packed {
    logic         key_n;
    logic         busy;
    logic [3:0]   pc;
    logic [W-1:0] lfsr;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: press lifetime tracked as remaining low / high cycle budgets.
  int m_lfsr = 0;
  int m_pc = 0;
  int m_low_left = 0;
  int m_high_left = 0;
  bit m_key = 1'b1;
  bit m_busy = 1'b0;

  function automatic int lfsr_step(input int q);
    int fb;
    fb = (((q >> (W - 1)) ^ (q >> (W - 4))) & 1) ^ 1;
    return ((q << 1) | fb) & ((1 << W) - 1);
  endfunction

  task automatic apply(input bit rst, input bit en, input int diff);
    bit trig;
    @(negedge clk);
    reset      = rst;
    enable     = en;
    difficulty = diff[W-2:0];
    trig = en && (diff == DMAX || diff > m_lfsr);
    if (rst) begin
      m_lfsr = 0; m_pc = 0; m_key = 1'b1; m_busy = 1'b0;
    end else begin
      if (!m_busy) begin
        if (trig) begin
          m_key = 1'b0;
          m_busy = 1'b1;
          m_low_left = H - 1;
          if (m_pc < 15) m_pc++;
        end
      end else if (!m_key) begin
        if (!en || m_low_left == 0) begin
          m_key = 1'b1;
          m_high_left = G - 1;
        end else begin
          m_low_left--;
        end
      end else begin
        if (m_high_left == 0) m_busy = 1'b0;
        else                  m_high_left--;
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
    sb.push_back(exp_t'{m_key, m_busy, 4'(m_pc), W'(m_lfsr)});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (exp_t'({key_n, busy, press_count, lfsr_q}) !== e) begin
          miscompares++;
          $display("FAIL vec%0d key_n/busy/press_count/lfsr_q got %b/%b/%0d/%h expected %b/%b/%0d/%h",
                   vectors, key_n, busy, press_count, lfsr_q, e.key_n, e.busy, e.pc, e.lfsr);
        end
      end
    end
  end

  initial begin : stimulus
    bit rst, en;
    int sel, diff;
    reset = 1'b1; enable = 1'b0; difficulty = '0;
    apply(1, 0, 0);
    apply(1, 0, 0);
    repeat (100) apply(0, 1, 0);
    apply(1, 1, DMAX);
    repeat (20) apply(0, 1, DMAX);
    apply(1, 1, DMAX);
    apply(0, 1, DMAX);
    repeat (8) apply(0, 0, DMAX);
    apply(1, 1, DMAX);
    apply(0, 1, DMAX);
    apply(1, 1, DMAX);
    repeat (6) apply(0, 1, DMAX);
    repeat (100) apply(0, 1, DMAX);
    repeat (3000) begin
      rst = ($urandom_range(0, 255) == 0);
      en  = ($urandom_range(0, 7) != 0);
      sel = $urandom_range(0, 9);
      diff = (sel == 0) ? 0 : (sel == 1) ? DMAX : int'($urandom_range(0, DMAX));
      apply(rst, en, diff);
    end
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
